// File: rtl/ps2_scan_decoder_if.sv
// Bundles the FIFO read side and the key-event side of the PS/2 scan decoder.
// master = decoder, slave = surrounding FIFO / key-event consumer.
interface ps2_scan_decoder_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       fifo_data;
  logic             fifo_ready;
  logic             fifo_overflow;
  logic             fifo_read;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_release;
  logic             key_valid;
  logic             key_ack;
  logic             proto_err;
  logic             ovf_seen;
  logic             clr_err;
  logic [CNT_W-1:0] evt_count;

  modport master (
    input  fifo_data, fifo_ready, fifo_overflow, key_ack, clr_err,
    output fifo_read, key_code, key_ext, key_release, key_valid,
           proto_err, ovf_seen, evt_count
  );

  modport slave (
    output fifo_data, fifo_ready, fifo_overflow, key_ack, clr_err,
    input  fifo_read, key_code, key_ext, key_release, key_valid,
           proto_err, ovf_seen, evt_count
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: pops FIFO bytes, folds E0/F0/E1 prefixes into
// one key event per handshake, flags protocol errors and sticky FIFO overflow.
module ps2_scan_decoder #(
  parameter int PAUSE_SKIP = 7,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                clrn,
  ps2_scan_decoder_if.master  bus
);

  localparam int SKIP_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EXT     = 3'd1;
  localparam logic [2:0] BRK     = 3'd2;
  localparam logic [2:0] EXT_BRK = 3'd3;
  localparam logic [2:0] PAUSE   = 3'd4;
  localparam logic [2:0] HOLD    = 3'd5;

  function automatic logic is_junk(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

  logic [2:0]        state_r, state_s;
  logic [SKIP_W-1:0] skip_r, skip_s;
  logic [7:0]        code_r, code_s;
  logic              ext_r, ext_s;
  logic              rel_r, rel_s;
  logic              valid_r, valid_s;
  logic              err_r, err_s;
  logic              ovf_r;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              pop_s;
  logic [7:0]        byte_s;

  assign pop_s  = bus.fifo_ready & clrn & (state_r != HOLD);
  assign byte_s = bus.fifo_data;

  // Next-state and event-latch decode for the prefix parser.
  always_comb begin
    state_s = state_r;
    skip_s  = skip_r;
    code_s  = code_r;
    ext_s   = ext_r;
    rel_s   = rel_r;
    valid_s = valid_r;
    err_s   = 1'b0;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (!pop_s) begin
          state_s = IDLE;
        end else if (byte_s == 8'hE0) begin
          state_s = EXT;
        end else if (byte_s == 8'hF0) begin
          state_s = BRK;
        end else if (byte_s == 8'hE1) begin
          state_s = PAUSE;
          skip_s  = SKIP_W'(PAUSE_SKIP);
        end else if (is_junk(byte_s)) begin
          err_s = 1'b1;
        end else begin
          state_s = HOLD;
          code_s  = byte_s;
          ext_s   = 1'b0;
          rel_s   = 1'b0;
          valid_s = 1'b1;
        end
      end
      EXT: begin
        if (!pop_s) begin
          state_s = EXT;
        end else if (byte_s == 8'hF0) begin
          state_s = EXT_BRK;
        end else if (is_prefix(byte_s) || is_junk(byte_s)) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
          code_s  = byte_s;
          ext_s   = 1'b1;
          rel_s   = 1'b0;
          valid_s = 1'b1;
        end
      end
      BRK, EXT_BRK: begin
        if (!pop_s) begin
          state_s = state_r;
        end else if (is_prefix(byte_s) || is_junk(byte_s)) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
          code_s  = byte_s;
          ext_s   = (state_r == EXT_BRK);
          rel_s   = 1'b1;
          valid_s = 1'b1;
        end
      end
      PAUSE: begin
        // Byte contents are ignored; only the count of consumed bytes matters.
        if (!pop_s) begin
          state_s = PAUSE;
        end else if (skip_r <= SKIP_W'(1)) begin
          skip_s  = SKIP_W'(0);
          state_s = HOLD;
          code_s  = 8'hE1;
          ext_s   = 1'b0;
          rel_s   = 1'b0;
          valid_s = 1'b1;
        end else begin
          skip_s = skip_r - SKIP_W'(1);
        end
      end
      HOLD: begin
        if (bus.key_ack) begin
          valid_s = 1'b0;
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // Parser state and presented-event registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_r <= IDLE;
      skip_r  <= SKIP_W'(0);
      code_r  <= 8'h00;
      ext_r   <= 1'b0;
      rel_r   <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= CNT_W'(0);
    end else begin
      state_r <= state_s;
      skip_r  <= skip_s;
      code_r  <= code_s;
      ext_r   <= ext_s;
      rel_r   <= rel_s;
      valid_r <= valid_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ovf_r <= 1'b0;
    end else if (bus.fifo_overflow) begin
      ovf_r <= 1'b1;
    end else if (bus.clr_err) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign bus.fifo_read   = pop_s;
  assign bus.key_code    = code_r;
  assign bus.key_ext     = ext_r;
  assign bus.key_release = rel_r;
  assign bus.key_valid   = valid_r;
  assign bus.proto_err   = err_r;
  assign bus.ovf_seen    = ovf_r;
  assign bus.evt_count   = cnt_r;

endmodule
